// File: rtl/des_block_packer_if.sv
// Byte-stream / cipher-side signal bundle for des_block_packer.
// master = byte source and cipher core side, slave = the packer itself.
interface des_block_packer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       byte_i;
    logic             byte_valid_i;
    logic             byte_last_i;
    logic             byte_ready_o;
    logic             cipher_rdy_i;
    logic [0:63]      data_o;
    logic             valid_o;
    logic             start_o;
    logic             last_o;
    logic [CNT_W-1:0] block_cnt_o;

    modport master (
        output byte_i, byte_valid_i, byte_last_i, cipher_rdy_i,
        input  byte_ready_o, data_o, valid_o, start_o, last_o, block_cnt_o
    );

    modport slave (
        input  byte_i, byte_valid_i, byte_last_i, cipher_rdy_i,
        output byte_ready_o, data_o, valid_o, start_o, last_o, block_cnt_o
    );
endinterface

// File: rtl/des_block_packer.sv
// Packs a byte stream into padded 64-bit blocks for the CBC triple-DES core.
// DES_PKCS7_PAD_EN selects PKCS#7 padding; otherwise final blocks are zero padded.
module des_block_packer #(
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    des_block_packer_if.slave bus
);

`ifdef DES_PKCS7_PAD_EN
    localparam bit PKCS7 = 1'b1;
`else
    localparam bit PKCS7 = 1'b0;
`endif

    typedef enum logic [1:0] {FILL, PAD, SEND, HOLD} state_e;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       blk_q [8];
    logic [7:0]       blk_d [8];
    logic             first_q, first_d;
    logic             last_flag_q, last_flag_d;
    logic             pad_pend_q, pad_pend_d;
    logic             byte_ready_q, byte_ready_d;
    logic [0:63]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] block_cnt_q, block_cnt_d;
    logic             accept;
    logic [7:0]       pad_val;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        first_d     = first_q;
        last_flag_d = last_flag_q;
        pad_pend_d  = pad_pend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        start_d     = 1'b0;
        last_d      = 1'b0;
        block_cnt_d = block_cnt_q;
        accept      = bus.byte_valid_i & byte_ready_q;
        // cnt_q = 0 only reaches PAD for the all-pad block, giving 8'h08
        pad_val     = PKCS7 ? (8'd8 - {5'd0, cnt_q}) : 8'h00;

        case (state_q)
            FILL: begin
                if (accept) begin
                    blk_d[cnt_q] = bus.byte_i;
                    cnt_d        = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = SEND;
                        if (bus.byte_last_i) begin
                            last_flag_d = !PKCS7;
                            pad_pend_d  = PKCS7;
                        end else begin
                            last_flag_d = 1'b0;
                        end
                    end else if (bus.byte_last_i) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                for (int unsigned s = 0; s < 8; s++) begin
                    if (3'(s) >= cnt_q) begin
                        blk_d[s] = pad_val;
                    end
                end
                cnt_d       = 3'd0;
                last_flag_d = 1'b1;
                pad_pend_d  = 1'b0;
                state_d     = SEND;
            end
            SEND: begin
                if (bus.cipher_rdy_i) begin
                    valid_d     = 1'b1;
                    data_d      = {blk_q[0], blk_q[1], blk_q[2], blk_q[3],
                                   blk_q[4], blk_q[5], blk_q[6], blk_q[7]};
                    start_d     = first_q;
                    last_d      = last_flag_q;
                    block_cnt_d = first_q ? CNT_W'(1) :
                                  ((block_cnt_q == '1) ? block_cnt_q : block_cnt_q + 1'b1);
                    first_d     = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (last_q) begin
                    first_d = 1'b1;
                    cnt_d   = 3'd0;
                end
                state_d = pad_pend_q ? PAD : FILL;
            end
            default: state_d = FILL;
        endcase

        byte_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            cnt_q        <= 3'd0;
            blk_q        <= '{default: '0};
            first_q      <= 1'b1;
            last_flag_q  <= 1'b0;
            pad_pend_q   <= 1'b0;
            byte_ready_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            start_q      <= 1'b0;
            last_q       <= 1'b0;
            block_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blk_q        <= blk_d;
            first_q      <= first_d;
            last_flag_q  <= last_flag_d;
            pad_pend_q   <= pad_pend_d;
            byte_ready_q <= byte_ready_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            start_q      <= start_d;
            last_q       <= last_d;
            block_cnt_q  <= block_cnt_d;
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.start_o      = start_q;
    assign bus.last_o       = last_q;
    assign bus.block_cnt_o  = block_cnt_q;

endmodule

// File: tb/tb_des_block_packer.sv
// Bench for des_block_packer: message-level block model plus literal spot checks.
// Honours DES_PKCS7_PAD_EN the same way as the design.
module tb_des_block_packer;

    localparam int unsigned CNT_W = 16;
`ifdef DES_PKCS7_PAD_EN
    localparam bit PKCS7 = 1'b1;
`else
    localparam bit PKCS7 = 1'b0;
`endif

    typedef struct packed {
        logic [63:0]      data;
        logic             start;
        logic             last;
        logic [CNT_W-1:0] cnt;
    } blk_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    int   rdy_mode;   // 0 low, 1 high, 2 random
    blk_t exp_q[$];
    blk_t obs_q[$];

    des_block_packer_if #(.CNT_W(CNT_W)) bus ();

    des_block_packer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Expected blocks for one message: 8-byte groups in arrival order, first byte
    // in the top byte, final partial group padded, optional extra all-pad block.
    task automatic model_msg(input logic [7:0] m[$]);
        int n;
        int rem;
        logic [63:0] d;
        logic [7:0] pv;
        logic [CNT_W-1:0] c;
        blk_t b;
        n = m.size();
        c = '0;
        for (int i = 0; i < n; i += 8) begin
            rem = n - i;
            pv  = PKCS7 ? 8'(8 - rem) : 8'h00;
            d   = '0;
            for (int j = 0; j < 8; j++) begin
                d = {d[55:0], (j < rem) ? m[i + j] : pv};
            end
            c       = (c == '1) ? c : c + 1'b1;
            b.data  = d;
            b.start = (i == 0);
            b.last  = (rem < 8) || (rem == 8 && !PKCS7);
            b.cnt   = c;
            exp_q.push_back(b);
            if (rem == 8 && PKCS7) begin
                c       = (c == '1) ? c : c + 1'b1;
                b.data  = 64'h0808080808080808;
                b.start = 1'b0;
                b.last  = 1'b1;
                b.cnt   = c;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last, input int gap);
        bit ok;
        bus.byte_valid_i = 1'b0;
        repeat (gap) begin
            bus.byte_i      = 8'($urandom);
            bus.byte_last_i = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.byte_i       = b;
        bus.byte_last_i  = last;
        bus.byte_valid_i = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (bus.byte_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL byte_accept_timeout: byte %h not accepted, required accept within 1000 cycles", b);
        end
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        bus.byte_last_i  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m[$], input int maxgap);
        model_msg(m);
        for (int i = 0; i < m.size(); i++) begin
            push_byte(m[i], i == m.size() - 1, $urandom_range(0, maxgap));
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d blocks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.cipher_rdy_i = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.cipher_rdy_i = 1'b0;
                1:       bus.cipher_rdy_i = 1'b1;
                default: bus.cipher_rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: every strobe against the model, idle outputs otherwise.
    initial begin
        logic        prev_v;
        logic [63:0] last_data;
        blk_t        e;
        blk_t        o;
        prev_v    = 1'b0;
        last_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_v    = 1'b0;
                last_data = '0;
            end else if (bus.valid_o) begin
                check("strobe_width", 64'(prev_v), 64'd0);
                o.data  = bus.data_o;
                o.start = bus.start_o;
                o.last  = bus.last_o;
                o.cnt   = bus.block_cnt_o;
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_block: got %h, required no block", o.data);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data",  o.data,        e.data);
                    check("blk_start", 64'(o.start),  64'(e.start));
                    check("blk_last",  64'(o.last),   64'(e.last));
                    check("blk_cnt",   64'(o.cnt),    64'(e.cnt));
                end
                last_data = bus.data_o;
                prev_v    = 1'b1;
            end else begin
                check("data_hold", bus.data_o, last_data);
                check("flags_idle", 64'({bus.start_o, bus.last_o}), 64'd0);
                prev_v = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] m[$];
        logic [7:0] m2[$];
        n_vec            = 0;
        n_bad            = 0;
        rdy_mode         = 1;
        reset            = 1'b0;
        bus.byte_i       = '0;
        bus.byte_valid_i = 1'b0;
        bus.byte_last_i  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.byte_ready_o), 64'd0);
        check("rst_data",  bus.data_o, 64'd0);
        check("rst_flags", 64'({bus.valid_o, bus.start_o, bus.last_o}), 64'd0);
        check("rst_cnt",   64'(bus.block_cnt_o), 64'd0);
        #2 reset = 1'b1;
        #1 check("ready_before_clk", 64'(bus.byte_ready_o), 64'd0);
        @(negedge clk);
        check("ready_after_clk", 64'(bus.byte_ready_o), 64'd1);

        // 1: exactly 8 bytes
        obs_q.delete();
        m.delete();
        for (int i = 1; i <= 8; i++) m.push_back(8'(i));
        send_msg(m, 0);
        drain();
        check("t1_nblk", 64'(obs_q.size()), PKCS7 ? 64'd2 : 64'd1);
        if (obs_q.size() > 0) begin
            check("t1_data",  obs_q[0].data, 64'h0102030405060708);
            check("t1_start", 64'(obs_q[0].start), 64'd1);
            check("t1_last",  64'(obs_q[0].last), PKCS7 ? 64'd0 : 64'd1);
        end
        if (obs_q.size() > 1) begin
            check("t1_pad_data", obs_q[1].data, 64'h0808080808080808);
            check("t1_pad_last", 64'(obs_q[1].last), 64'd1);
            check("t1_pad_cnt",  64'(obs_q[1].cnt), 64'd2);
        end

        // 2: short message padded
        obs_q.delete();
        m = '{8'hAA, 8'hBB, 8'hCC};
        send_msg(m, 1);
        drain();
        if (obs_q.size() > 0) begin
            check("t2_data", obs_q[0].data, PKCS7 ? 64'hAABBCC0505050505 : 64'hAABBCC0000000000);
            check("t2_flags", 64'({obs_q[0].start, obs_q[0].last}), 64'd3);
        end else check("t2_nblk", 64'(obs_q.size()), 64'd1);

        // 3: cipher stalled after the first full block
        obs_q.delete();
        m.delete();
        for (int i = 0; i < 16; i++) m.push_back(8'(i));
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        model_msg(m);
        for (int i = 0; i < 8; i++) push_byte(m[i], 1'b0, 0);
        repeat (20) begin
            check("t3_stall_valid", 64'(bus.valid_o), 64'd0);
            check("t3_stall_ready", 64'(bus.byte_ready_o), 64'd0);
            @(negedge clk);
        end
        rdy_mode = 1;
        for (int i = 8; i < 16; i++) push_byte(m[i], i == 15, 0);
        drain();
        if (obs_q.size() > 1) begin
            check("t3_blk0", obs_q[0].data, 64'h0001020304050607);
            check("t3_start0", 64'(obs_q[0].start), 64'd1);
            check("t3_blk1", obs_q[1].data, 64'h08090A0B0C0D0E0F);
            check("t3_start1", 64'(obs_q[1].start), 64'd0);
        end else check("t3_nblk", 64'(obs_q.size()), 64'd2);

        // 4: back-to-back messages
        obs_q.delete();
        m  = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        m2 = '{8'h77};
        send_msg(m, 0);
        send_msg(m2, 0);
        drain();
        if (obs_q.size() > 1) begin
            check("t4_data0", obs_q[0].data, PKCS7 ? 64'h1112131415030303 : 64'h1112131415000000);
            check("t4_data1", obs_q[1].data, PKCS7 ? 64'h7707070707070707 : 64'h7700000000000000);
            check("t4_start1", 64'(obs_q[1].start), 64'd1);
            check("t4_cnt1", 64'(obs_q[1].cnt), 64'd1);
        end else check("t4_nblk", 64'(obs_q.size()), 64'd2);

        // 5: reset in mid-message
        obs_q.delete();
        for (int i = 0; i < 4; i++) push_byte(8'hE0 + 8'(i), 1'b0, 0);
        #2 reset = 1'b0;
        #1 begin
            check("t5_rst_ready", 64'(bus.byte_ready_o), 64'd0);
            check("t5_rst_data",  bus.data_o, 64'd0);
            check("t5_rst_flags", 64'({bus.valid_o, bus.start_o, bus.last_o}), 64'd0);
            check("t5_rst_cnt",   64'(bus.block_cnt_o), 64'd0);
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        m.delete();
        for (int i = 0; i < 8; i++) m.push_back(8'h10 + 8'(i));
        send_msg(m, 0);
        drain();
        if (obs_q.size() > 0) begin
            check("t5_data", obs_q[0].data, 64'h1011121314151617);
            check("t5_start", 64'(obs_q[0].start), 64'd1);
            check("t5_cnt", 64'(obs_q[0].cnt), 64'd1);
        end else check("t5_nblk", 64'(obs_q.size()), 64'd1);

        // 6: random gaps and random cipher readiness
        rdy_mode = 2;
        for (int n = 0; n < 12; n++) begin
            m.delete();
            for (int i = 0; i < int'($urandom_range(1, 20)); i++) m.push_back(8'($urandom));
            send_msg(m, 3);
            drain();
        end
        rdy_mode = 1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
